// File: rtl/add_status_pkg.sv
// Shared types and result classification for the add/status pipeline.
package add_status_pkg;

   typedef enum logic [1:0] {WRAP = 2'b00, SAT = 2'b01, ACC = 2'b10, RSVD = 2'b11} mode_e;
   typedef enum logic [1:0] {ZERO = 2'b00, MAX = 2'b01, OTHER = 2'b10, OVF = 2'b11} status_e;

   localparam int MAX_W = 64;

   // r is zero-extended to MAX_W+1 bits; width selects the live result width.
   // Returns {sum[MAX_W-1:0], status}; callers keep the low width+2 bits.
   function automatic logic [MAX_W+1:0] classify(input logic [MAX_W:0] r, input mode_e mode,
                                                 input int width);
      logic [MAX_W:0]   ones;
      logic [MAX_W-1:0] s;
      logic             carry;
      status_e          st;
      ones = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < width) ones[i] = 1'b1;
      end
      carry = |(r & ~ones);
      if (carry && mode == SAT) s = ones[MAX_W-1:0];
      else                      s = r[MAX_W-1:0] & ones[MAX_W-1:0];
      if (carry)                         st = OVF;
      else if (s == '0)                  st = ZERO;
      else if (s == ones[MAX_W-1:0])     st = MAX;
      else                               st = OTHER;
      return {s, st};
   endfunction

endpackage

// File: rtl/add_status_stage.sv
// Generic valid/ready pipeline register; ready passes through when the stage drains.
module add_status_stage #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/add_status_pipe.sv
// Two-stage add/status pipeline: S1 computes the carry-extended result, S2 holds
// the classified sum/status. The accumulator updates at S1 acceptance.
import add_status_pkg::*;

module add_status_pipe #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic [1:0]       status,
   output logic             ovf_sticky
);

   localparam int S1_W = WIDTH + 3;
   localparam int S2_W = WIDTH + 2;

   logic [WIDTH-1:0] acc;
   logic [WIDTH:0]   r_p0;
   logic             is_acc_p0;
   logic             accept_p0;
   logic [S1_W-1:0]  data_p1;
   logic             vld_p1;
   logic             ready_p1;
   logic [WIDTH:0]   r_p1;
   logic [1:0]       mode_p1;
   logic [MAX_W+1:0] cls_p1;
   logic             load_p1;
   logic             unused_cls;
   logic [S2_W-1:0]  data_p2;

   // Stage 0 -> 1: operand add with carry
   assign is_acc_p0 = (mode_e'(mode) == ACC);
   assign r_p0      = is_acc_p0 ? ({1'b0, acc} + {1'b0, a}) : ({1'b0, a} + {1'b0, b});
   assign accept_p0 = in_valid && in_ready;

   add_status_stage #(.PW(S1_W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({r_p0, mode}),
      .out_valid (vld_p1),
      .out_ready (ready_p1),
      .out_data  (data_p1)
   );

   // Stage 1 -> 2: saturation and classification
   assign {r_p1, mode_p1} = data_p1;
   assign cls_p1     = classify((MAX_W+1)'(r_p1), mode_e'(mode_p1), WIDTH);
   assign unused_cls = ^cls_p1[MAX_W+1:WIDTH+2];
   assign load_p1    = vld_p1 && ready_p1;

   add_status_stage #(.PW(S2_W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_p1),
      .in_ready  (ready_p1),
      .in_data   (cls_p1[WIDTH+1:0]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (data_p2)
   );

   assign sum    = data_p2[WIDTH+1:2];
   assign status = data_p2[1:0];

   // clr wins the accumulator; an OVF result entering S2 wins the sticky flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= ACC_INIT;
         ovf_sticky <= 1'b0;
      end else begin
         if (clr)                         acc <= ACC_INIT;
         else if (accept_p0 && is_acc_p0) acc <= r_p0[WIDTH-1:0];
         if (load_p1 && status_e'(cls_p1[1:0]) == OVF) ovf_sticky <= 1'b1;
         else if (clr)                                 ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_status_pipe.sv
// Scoreboard bench for add_status_pipe: directed cases followed by random traffic.
module tb_add_status_pipe;
   import add_status_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [1:0]   mode = 2'b00;
   logic         clr = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic [1:0]   status;
   logic         ovf_sticky;

   int errors = 0;
   int checks = 0;
   int acc_m  = 0;
   bit rand_ready = 1'b0;

   typedef struct {int s; int st;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   add_status_pipe #(.WIDTH(W), .ACC_INIT('0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .mode       (mode),
      .clr        (clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sum        (sum),
      .status     (status),
      .ovf_sticky (ovf_sticky)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the mode rules.
   task automatic model(input int av, input int bv, input int m, input bit c);
      exp_t e;
      int   r;
      r    = (m == 2) ? acc_m + av : av + bv;
      e.s  = (r > 255 && m == 1) ? 255 : r % 256;
      e.st = (r > 255) ? 3 : (e.s == 0) ? 0 : (e.s == 255) ? 1 : 2;
      sb.push_back(e);
      if (c)           acc_m = 0;
      else if (m == 2) acc_m = r % 256;
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
   endtask

   task automatic send(input int av, input int bv, input int m, input bit c);
      int n;
      n = 0;
      tick();
      a = av[W-1:0];
      b = bv[W-1:0];
      mode = m[1:0];
      clr = c;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         tick();
         #1;
         n++;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      else           model(av, bv, m, c);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         in_valid = 1'b0;
         clr = 1'b0;
      end
   endtask

   // Monitor: pops on every output handshake and checks hold stability under stall.
   initial begin
      logic [W-1:0] held;
      bit           holding;
      exp_t         e;
      holding = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            holding = 1'b0;
         end else begin
            if (holding) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_sum", sum, held);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", out_valid, 0);
               end else begin
                  e = sb.pop_front();
                  chk("sum", sum, e.s);
                  chk("status", status, e.st);
               end
            end
            holding = out_valid && !out_ready;
            held = sum;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_status", status, 0);
      chk("rst_sticky", ovf_sticky, 0);
      @(negedge clk);
      rst_n = 1'b1;

      send(3, 4, 0, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("lat_edge1", out_valid, 0);
      tick();
      #1;
      chk("lat_edge2", out_valid, 1);

      send(200, 100, 0, 0);
      send(200, 100, 1, 0);
      send(255, 0, 1, 0);
      idle(4);
      #1;
      chk("sticky_set", ovf_sticky, 1);
      tick();
      clr = 1'b1;
      acc_m = 0;
      tick();
      clr = 1'b0;
      #1;
      chk("sticky_clr", ovf_sticky, 0);

      send(10, 0, 2, 0);
      send(20, 99, 2, 0);
      send(30, 0, 2, 0);
      send(5, 0, 2, 1);
      send(1, 0, 2, 0);
      idle(4);

      out_ready = 1'b0;
      send(1, 0, 0, 0);
      send(2, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 1);
      idle(3);
      out_ready = 1'b1;
      send(3, 0, 0, 0);
      send(4, 0, 0, 0);
      send(0, 0, 0, 0);
      send(128, 128, 3, 0);
      idle(4);

      out_ready = 1'b0;
      send(7, 1, 0, 0);
      send(9, 1, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      sb.delete();
      acc_m = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      out_ready = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(6);

      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0));
      end
      idle(1);
      rand_ready = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
